// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle RISC-V sequencing controller.
// Holds the state encoding, opcode constants, the latched instruction-class
// encoding, ALUOp codes, and small helpers that map an opcode to its class
// and a class to its ALU operation and operand source.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        StFetch     = 3'd0,
        StDecode    = 3'd1,
        StExecute   = 3'd2,
        StMem       = 3'd3,
        StWriteback = 3'd4,
        StError     = 3'd5
    } state_e;

    localparam logic [6:0] OpcR  = 7'b0110011;
    localparam logic [6:0] OpcI  = 7'b0010011;
    localparam logic [6:0] OpcLd = 7'b0000011;
    localparam logic [6:0] OpcSt = 7'b0100011;
    localparam logic [6:0] OpcBr = 7'b1100011;

    // ClsNone is the post-reset value before any instruction has been decoded.
    typedef enum logic [2:0] {
        ClsNone    = 3'd0,
        ClsR       = 3'd1,
        ClsI       = 3'd2,
        ClsLd      = 3'd3,
        ClsSt      = 3'd4,
        ClsBr      = 3'd5,
        ClsIllegal = 3'd6
    } iclass_e;

    localparam logic [1:0] AluOpMem    = 2'b00;
    localparam logic [1:0] AluOpBranch = 2'b01;
    localparam logic [1:0] AluOpArith  = 2'b10;

    function automatic iclass_e decode_opcode(input logic [6:0] op);
        case (op)
            OpcR:    return ClsR;
            OpcI:    return ClsI;
            OpcLd:   return ClsLd;
            OpcSt:   return ClsSt;
            OpcBr:   return ClsBr;
            default: return ClsIllegal;
        endcase
    endfunction

    function automatic logic [1:0] alu_op_of(input iclass_e cls);
        case (cls)
            ClsBr:        return AluOpBranch;
            ClsR, ClsI:   return AluOpArith;
            default:      return AluOpMem;
        endcase
    endfunction

    function automatic logic uses_imm(input iclass_e cls);
        return (cls == ClsI) || (cls == ClsLd) || (cls == ClsSt);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory-wait watchdog counter.
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous active-low reset
//   clear    - synchronous clear of the wait count (takes priority)
//   enable   - count one more cycle of waiting
//   timeout  - high while the count equals TIMEOUT_CYCLES
module mem_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES);

    logic [CntW-1:0] count_q;

    // Saturates at Limit so the count never wraps back below the threshold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && (count_q != Limit)) begin
            count_q <= count_q + CntW'(1);
        end
    end

    assign timeout = (count_q == Limit);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Sequencing controller for a multi-cycle RISC-V datapath.
// Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK,
// handshaking with variable-latency instruction and data memories.
// Ports:
//   clk, reset                 - clock and asynchronous active-low reset
//   opcode, zero               - IR opcode field and ALU zero flag
//   imem_ready, dmem_ready     - memory access complete this cycle
//   imem_req, ir_write         - fetch request / IR latch enable
//   pc_write, pc_src           - PC update enable / 0: PC+4, 1: branch target
//   reg_write, mem_to_reg      - register file write enable / writeback select
//   dmem_read, dmem_write      - data memory requests
//   alu_src, alu_op            - ALU operand select / operation class
//   state_o, error, retired    - debug state, sticky error, retired count
module multicycle_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             reg_write,
    output logic             dmem_read,
    output logic             dmem_write,
    output logic             alu_src,
    output logic             mem_to_reg,
    output logic [1:0]       alu_op,
    output logic [2:0]       state_o,
    output logic             error,
    output logic [CNT_W-1:0] retired
);

    state_e          state_q, state_d;
    iclass_e         cls_q, cls_d;
    logic [CNT_W-1:0] retired_q;
    logic            retire;
    logic            waiting, ready_sel, timeout;

    // Only FETCH and MEM wait on a memory; ready elsewhere is ignored.
    assign waiting   = (state_q == StFetch) || (state_q == StMem);
    assign ready_sel = (state_q == StFetch) ? imem_ready : dmem_ready;

    mem_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_mem_wait_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (!waiting || ready_sel),
        .enable (waiting && !ready_sel),
        .timeout(timeout)
    );

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        retire  = 1'b0;
        unique case (state_q)
            StFetch: begin
                if (imem_ready) begin
                    state_d = StDecode;
                end else if (timeout) begin
                    state_d = StError;
                end
            end
            StDecode: begin
                cls_d   = decode_opcode(opcode);
                state_d = (cls_d == ClsIllegal) ? StError : StExecute;
            end
            StExecute: begin
                case (cls_q)
                    ClsBr: begin
                        retire  = 1'b1;
                        state_d = StFetch;
                    end
                    ClsLd, ClsSt: state_d = StMem;
                    default:      state_d = StWriteback;
                endcase
            end
            StMem: begin
                if (dmem_ready) begin
                    if (cls_q == ClsSt) begin
                        retire  = 1'b1;
                        state_d = StFetch;
                    end else begin
                        state_d = StWriteback;
                    end
                end else if (timeout) begin
                    state_d = StError;
                end
            end
            StWriteback: begin
                retire  = 1'b1;
                state_d = StFetch;
            end
            StError: state_d = StError;
            default: state_d = StError;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StFetch;
            cls_q     <= ClsNone;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    // Outputs are gated by reset so nothing (not even imem_req) is asserted
    // while reset is held, even though the state register sits in FETCH.
    always_comb begin
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        dmem_read  = 1'b0;
        dmem_write = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        alu_op     = 2'b00;
        error      = 1'b0;
        if (reset) begin
            unique case (state_q)
                StFetch: begin
                    imem_req = 1'b1;
                    ir_write = imem_ready;
                end
                StDecode: ;
                StExecute: begin
                    alu_src = uses_imm(cls_q);
                    alu_op  = alu_op_of(cls_q);
                    if (cls_q == ClsBr) begin
                        pc_write = 1'b1;
                        pc_src   = zero;
                    end
                end
                StMem: begin
                    alu_src    = uses_imm(cls_q);
                    alu_op     = alu_op_of(cls_q);
                    dmem_read  = (cls_q == ClsLd);
                    dmem_write = (cls_q == ClsSt);
                    pc_write   = (cls_q == ClsSt) && dmem_ready;
                end
                StWriteback: begin
                    alu_src    = uses_imm(cls_q);
                    alu_op     = alu_op_of(cls_q);
                    reg_write  = 1'b1;
                    mem_to_reg = (cls_q == ClsLd);
                    pc_write   = 1'b1;
                end
                StError: error = 1'b1;
                default: error = 1'b1;
            endcase
        end
    end

    assign state_o = state_q;
    assign retired = retired_q;

endmodule
